// File: rtl/cdc_channel_arbiter.sv
// cdc_channel_arbiter
// Round-robin arbiter that serialises R requesters onto one four-phase
// xreq/xack handshake toward a destination clock domain. xack arrives
// already synchronised into dclk. Every output is registered.
// Build option: define CDC_ARB_TIMEOUT_EN to add a T-cycle watchdog on the
// REQ and REL phases. Without it, timeout_err is constant 0 and both phases
// wait for xack indefinitely.

module cdc_channel_arbiter #(
  parameter int N = 8,
  parameter int R = 4,
  parameter int T = 64
) (
  input  logic                                 dclk,
  input  logic                                 drstn,
  input  logic [R-1:0]                         req_valid,
  input  logic [R*N-1:0]                       req_data,
  output logic [R-1:0]                         req_done,
  output logic                                 xreq,
  output logic [N-1:0]                         xdat,
  input  logic                                 xack,
  output logic                                 busy,
  output logic [((R > 1) ? $clog2(R) : 1)-1:0] grant_id,
  output logic                                 timeout_err
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2
  } state_t;

  // Reject configurations the round-robin search and watchdog do not support.
  if (R < 2 || R > 16 || T < 2) begin : g_bad_param
    $error("cdc_channel_arbiter: R must be 2..16 and T at least 2");
  end

  // First requesting index at or after 'start', wrapping modulo R.
  function automatic logic [IW-1:0] rr_pick(input logic [R-1:0]  v,
                                            input logic [IW-1:0] start);
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < R; i++) begin
      idx = IW'((int'(start) + i) % R);
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Payload slice belonging to requester 'sel'.
  function automatic logic [N-1:0] slice_of(input logic [R*N-1:0] d,
                                            input logic [IW-1:0]  sel);
    logic [N-1:0] res;
    res = '0;
    for (int r = 0; r < R; r++) begin
      if (sel == IW'(r)) begin
        res = d[r*N +: N];
      end
    end
    return res;
  endfunction

  state_t        state_r, state_s;
  logic          xreq_r, xreq_s;
  logic [N-1:0]  xdat_r, xdat_s;
  logic [IW-1:0] gid_r, gid_s;
  logic [IW-1:0] ptr_r, ptr_s;
  logic [R-1:0]  done_r, done_s;
  logic          busy_r, busy_s;
  logic [IW-1:0] win_s;

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CW = (T > 2) ? $clog2(T) : 1;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          terr_r, terr_s;
`endif

  assign win_s = rr_pick(req_valid, ptr_r);

  // Next-state and next-output computation for the handshake FSM.
  always_comb begin
    state_s = state_r;
    xreq_s  = xreq_r;
    xdat_s  = xdat_r;
    gid_s   = gid_r;
    ptr_s   = ptr_r;
    done_s  = '0;
`ifdef CDC_ARB_TIMEOUT_EN
    cnt_s   = cnt_r;
    terr_s  = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        // A still-high xack belongs to the previous transfer: hold off.
        if ((|req_valid) && !xack) begin
          state_s = S_REQ;
          xreq_s  = 1'b1;
          xdat_s  = slice_of(req_data, win_s);
          gid_s   = win_s;
          ptr_s   = IW'((int'(win_s) + 1) % R);
`ifdef CDC_ARB_TIMEOUT_EN
          cnt_s   = '0;
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (xack) begin
          state_s = S_REL;
          xreq_s  = 1'b0;
`ifdef CDC_ARB_TIMEOUT_EN
          cnt_s   = '0;
`endif
        end
`ifdef CDC_ARB_TIMEOUT_EN
        else if (cnt_r == CW'(T - 2)) begin
          state_s = S_REL;
          xreq_s  = 1'b0;
          terr_s  = 1'b1;
          cnt_s   = '0;
        end else begin
          state_s = S_REQ;
          cnt_s   = cnt_r + CW'(1);
        end
`else
        else begin
          state_s = S_REQ;
        end
`endif
      end
      S_REL: begin
        if (!xack) begin
          state_s       = S_IDLE;
          done_s[gid_r] = 1'b1;
        end
`ifdef CDC_ARB_TIMEOUT_EN
        else if (cnt_r == CW'(T - 2)) begin
          state_s       = S_IDLE;
          done_s[gid_r] = 1'b1;
          terr_s        = 1'b1;
        end else begin
          state_s = S_REL;
          cnt_s   = cnt_r + CW'(1);
        end
`else
        else begin
          state_s = S_REL;
        end
`endif
      end
      default: begin
        state_s = S_IDLE;
        xreq_s  = 1'b0;
      end
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // FSM state register.
  always_ff @(posedge dclk) begin
    if (!drstn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered handshake outputs, grant bookkeeping and round-robin pointer.
  always_ff @(posedge dclk) begin
    if (!drstn) begin
      xreq_r <= 1'b0;
      xdat_r <= '0;
      gid_r  <= '0;
      ptr_r  <= '0;
      done_r <= '0;
      busy_r <= 1'b0;
    end else begin
      xreq_r <= xreq_s;
      xdat_r <= xdat_s;
      gid_r  <= gid_s;
      ptr_r  <= ptr_s;
      done_r <= done_s;
      busy_r <= busy_s;
    end
  end

`ifdef CDC_ARB_TIMEOUT_EN
  // Watchdog counter and timeout pulse register.
  always_ff @(posedge dclk) begin
    if (!drstn) begin
      cnt_r  <= '0;
      terr_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      terr_r <= terr_s;
    end
  end

  assign timeout_err = terr_r;
`else
  assign timeout_err = 1'b0;
`endif

  assign xreq     = xreq_r;
  assign xdat     = xdat_r;
  assign grant_id = gid_r;
  assign req_done = done_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_cdc_channel_arbiter.sv
// Self-checking bench for cdc_channel_arbiter (N=8, R=4, T=16).
// Directed scenarios use constant expectations; the randomized scenario is
// checked against a transaction-style reference model.
`timescale 1ns/1ps

module tb_cdc_channel_arbiter;

  localparam int N  = 8;
  localparam int R  = 4;
  localparam int T  = 16;
  localparam int IW = 2;

  logic           dclk = 1'b0;
  logic           drstn;
  logic [R-1:0]   req_valid;
  logic [R*N-1:0] req_data;
  logic [R-1:0]   req_done;
  logic           xreq;
  logic [N-1:0]   xdat;
  logic           xack;
  logic           busy;
  logic [IW-1:0]  grant_id;
  logic           timeout_err;

  int tests = 0;
  int fails = 0;

  // destination-side echo responder
  logic [7:0] ack_hist;
  int         ack_lag;
  bit         ack_auto;

  // reference model state
  int           m_phase;   // 0 idle, 1 request, 2 release
  int           m_ptr;
  int           m_gid;
  logic [N-1:0] m_xdat;
  logic [R-1:0] m_done;

  cdc_channel_arbiter #(.N(N), .R(R), .T(T)) dut (
    .dclk        (dclk),
    .drstn       (drstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_done    (req_done),
    .xreq        (xreq),
    .xdat        (xdat),
    .xack        (xack),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 dclk = ~dclk;

  // Round-robin winner: rotate the request vector so the search start is bit 0.
  function automatic int rr_winner(input logic [R-1:0] v, input int ptr);
    logic [2*R-1:0] dbl;
    dbl = {v, v} >> ptr;
    for (int k = 0; k < R; k++) begin
      if (dbl[k]) return (ptr + k) % R;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_gid   = 0;
    m_xdat  = '0;
    m_done  = '0;
  endtask

  // Advance the model by one dclk edge using the inputs currently applied.
  task automatic model_step();
    int w;
    m_done = '0;
    if (!drstn) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (req_valid != '0 && !xack) begin
             w       = rr_winner(req_valid, m_ptr);
             m_gid   = w;
             m_xdat  = req_data[w*N +: N];
             m_ptr   = (w + 1) % R;
             m_phase = 1;
           end
        1: if (xack) m_phase = 2;
        2: if (!xack) begin
             m_done[m_gid] = 1'b1;
             m_phase       = 0;
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  // One clock: model update, active edge, then settle at the falling edge.
  task automatic tick();
    model_step();
    @(posedge dclk);
    @(negedge dclk);
    ack_hist = {ack_hist[6:0], xreq};
    if (ack_auto) xack = ack_hist[ack_lag-1];
  endtask

  task automatic do_reset();
    drstn     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    xack      = 1'b0;
    ack_auto  = 1'b0;
    ack_lag   = 1;
    ack_hist  = '0;
    tick();
    tick();
    drstn = 1'b1;
  endtask

  task automatic test_reset();
    drstn     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'hDEADBEEF;
    xack      = 1'b0;
    ack_auto  = 1'b0;
    ack_hist  = '0;
    tick();
    tick();
    tests++; if (xreq !== 1'b0) begin fails++; $display("FAIL reset_xreq: got %0b want 0", xreq); end
    tests++; if (xdat !== 8'h00) begin fails++; $display("FAIL reset_xdat: got %h want 00", xdat); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests++; if (req_done !== 4'b0000) begin fails++; $display("FAIL reset_done: got %b want 0000", req_done); end
    tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_terr: got %0b want 0", timeout_err); end
  endtask

  task automatic test_single();
    int fall_cyc;
    logic prev_ack;
    do_reset();
    ack_auto = 1'b1;
    ack_lag  = 2;
    req_data[1*N +: N] = 8'hA5;
    req_valid = 4'b0010;
    tick();
    tests++; if (xreq !== 1'b1) begin fails++; $display("FAIL single_xreq: got %0b want 1", xreq); end
    tests++; if (xdat !== 8'hA5) begin fails++; $display("FAIL single_xdat: got %h want a5", xdat); end
    tests++; if (grant_id !== 2'd1) begin fails++; $display("FAIL single_grant: got %0d want 1", grant_id); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %0b want 1", busy); end
    fall_cyc = -1;
    for (int c = 2; c <= 5; c++) begin
      prev_ack = xack;
      tick();
      if (prev_ack && !xack) fall_cyc = c;
      if (c == 3) begin
        tests++; if (xreq !== 1'b0) begin fails++; $display("FAIL single_release: got %0b want 0", xreq); end
      end
      if (c < 5) begin
        tests++; if (req_done !== 4'b0000) begin fails++; $display("FAIL single_early_done: cyc %0d got %b want 0000", c, req_done); end
      end else begin
        tests++; if (req_done !== 4'b0010) begin fails++; $display("FAIL single_done: got %b want 0010", req_done); end
      end
    end
    tests++; if (fall_cyc !== 4) begin fails++; $display("FAIL single_ack_fall: got cycle %0d want 4", fall_cyc); end
    req_valid = '0;
    tick();
    tests++; if (req_done !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL single_after: done %b busy %0b want 0000 0", req_done, busy); end
  endtask

  task automatic test_round_robin();
    int   exp_order[5] = '{0, 1, 2, 3, 0};
    int   got_order[5];
    int   ngrant, ndone, last;
    logic prev_xreq;
    do_reset();
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    ack_auto  = 1'b1;
    ack_lag   = 1;
    ngrant = 0; ndone = 0; last = 0;
    for (int c = 0; c < 200 && ngrant < 5; c++) begin
      prev_xreq = xreq;
      tick();
      if (req_done != '0) begin
        ndone++;
        tests++;
        if (req_done !== (4'b0001 << last)) begin fails++; $display("FAIL rr_done: got %b want %b", req_done, 4'b0001 << last); end
      end
      if (xreq && !prev_xreq) begin
        got_order[ngrant] = int'(grant_id);
        last = int'(grant_id);
        tests++;
        if (xdat !== req_data[last*N +: N]) begin fails++; $display("FAIL rr_xdat: got %h want %h", xdat, req_data[last*N +: N]); end
        ngrant++;
      end
    end
    tests++;
    if (ngrant != 5) begin
      fails++; $display("FAIL rr_budget: got %0d grants want 5", ngrant);
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++; if (got_order[i] != exp_order[i]) begin fails++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, got_order[i], exp_order[i]); end
      end
    end
    tests++; if (ndone != 4) begin fails++; $display("FAIL rr_done_count: got %0d want 4", ndone); end
  endtask

  task automatic test_drop_mid();
    do_reset();
    req_data[0 +: N] = 8'h3C;
    req_valid = 4'b0001;
    tick();
    tests++; if (grant_id !== 2'd0 || xreq !== 1'b1) begin fails++; $display("FAIL drop_grant: grant %0d xreq %0b want 0 1", grant_id, xreq); end
    req_valid = 4'b0100;
    req_data[0 +: N]   = 8'h00;
    req_data[2*N +: N] = 8'h77;
    tick();
    tick();
    tests++; if (xdat !== 8'h3C) begin fails++; $display("FAIL drop_xdat_req: got %h want 3c", xdat); end
    tests++; if (grant_id !== 2'd0 || xreq !== 1'b1) begin fails++; $display("FAIL drop_hold: grant %0d xreq %0b want 0 1", grant_id, xreq); end
    tests++; if (req_done !== 4'b0000) begin fails++; $display("FAIL drop_early_done: got %b want 0000", req_done); end
    req_valid = 4'b0000;
    xack = 1'b1;
    tick();
    tests++; if (xreq !== 1'b0 || xdat !== 8'h3C) begin fails++; $display("FAIL drop_rel: xreq %0b xdat %h want 0 3c", xreq, xdat); end
    xack = 1'b0;
    tick();
    tests++; if (req_done !== 4'b0001) begin fails++; $display("FAIL drop_done: got %b want 0001", req_done); end
    tick();
    tests++; if (req_done !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL drop_idle: done %b busy %0b want 0000 0", req_done, busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data[2*N +: N] = 8'h5A;
    req_valid = 4'b0100;
    tick();
    tests++; if (grant_id !== 2'd2 || xreq !== 1'b1) begin fails++; $display("FAIL rmid_grant: grant %0d xreq %0b want 2 1", grant_id, xreq); end
    drstn = 1'b0;
    tick();
    tests++; if (xreq !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_drop: xreq %0b busy %0b want 0 0", xreq, busy); end
    tests++; if (req_done !== 4'b0000) begin fails++; $display("FAIL rmid_done: got %b want 0000", req_done); end
    tests++; if (grant_id !== 2'd0 || xdat !== 8'h00) begin fails++; $display("FAIL rmid_clear: grant %0d xdat %h want 0 00", grant_id, xdat); end
    drstn = 1'b1;
    req_valid = 4'b1111;
    tick();
    tests++; if (grant_id !== 2'd0 || xreq !== 1'b1) begin fails++; $display("FAIL rmid_ptr: grant %0d xreq %0b want 0 1", grant_id, xreq); end
    xack = 1'b1;
    tick();
    xack = 1'b0;
    req_valid = 4'b0000;
    tick();
    tests++; if (req_done !== 4'b0001) begin fails++; $display("FAIL rmid_after_done: got %b want 0001", req_done); end
    tick();
  endtask

  task automatic test_stale_ack();
    drstn     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h0;
    xack      = 1'b1;
    ack_auto  = 1'b0;
    tick();
    drstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++; if (xreq !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL stale_grant: cyc %0d xreq %0b busy %0b want 0 0", c, xreq, busy); end
    end
    xack = 1'b0;
    tick();
    tests++; if (xreq !== 1'b1 || grant_id !== 2'd0) begin fails++; $display("FAIL stale_release: xreq %0b grant %0d want 1 0", xreq, grant_id); end
    xack = 1'b1;
    req_valid = 4'b0000;
    tick();
    xack = 1'b0;
    tick();
    tests++; if (req_done !== 4'b0001) begin fails++; $display("FAIL stale_done: got %b want 0001", req_done); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    ack_auto = 1'b1;
    ack_lag  = 2;
    for (int c = 0; c < 2000; c++) begin
      tick();
      tests++; if (xreq !== (m_phase == 1)) begin fails++; $display("FAIL rand_xreq: cyc %0d got %0b want %0b", c, xreq, m_phase == 1); end
      tests++; if (busy !== (m_phase != 0)) begin fails++; $display("FAIL rand_busy: cyc %0d got %0b want %0b", c, busy, m_phase != 0); end
      tests++; if (grant_id !== IW'(m_gid)) begin fails++; $display("FAIL rand_grant: cyc %0d got %0d want %0d", c, grant_id, m_gid); end
      tests++; if (xdat !== m_xdat) begin fails++; $display("FAIL rand_xdat: cyc %0d got %h want %h", c, xdat, m_xdat); end
      tests++; if (req_done !== m_done) begin fails++; $display("FAIL rand_done: cyc %0d got %b want %b", c, req_done, m_done); end
      tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rand_terr: cyc %0d got %0b want 0", c, timeout_err); end
      // new stimulus for the next edge
      drstn = ($urandom_range(0, 299) != 0);
      for (int r = 0; r < R; r++) begin
        if (m_done[r]) begin
          req_valid[r] = 1'b0;
        end else if (!req_valid[r] && $urandom_range(0, 3) == 0) begin
          req_data[r*N +: N] = 8'($urandom);
          req_valid[r] = 1'b1;
        end else if (req_valid[r] && $urandom_range(0, 31) == 0) begin
          req_valid[r] = 1'b0;
        end
      end
      if (c % 250 == 249) ack_lag = $urandom_range(1, 3);
    end
    drstn = 1'b1;
  endtask

`ifdef CDC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_data[0 +: N] = 8'h99;
    req_valid = 4'b0001;
    tick();
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k < 15) begin
        tests++; if (timeout_err !== 1'b0 || xreq !== 1'b1) begin fails++; $display("FAIL tmo_req_early: k %0d terr %0b xreq %0b want 0 1", k, timeout_err, xreq); end
      end else begin
        tests++; if (timeout_err !== 1'b1 || xreq !== 1'b0) begin fails++; $display("FAIL tmo_req: terr %0b xreq %0b want 1 0", timeout_err, xreq); end
      end
    end
    xack = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k < 15) begin
        tests++; if (timeout_err !== 1'b0 || req_done !== 4'b0000) begin fails++; $display("FAIL tmo_rel_early: k %0d terr %0b done %b want 0 0000", k, timeout_err, req_done); end
      end else begin
        tests++; if (timeout_err !== 1'b1 || req_done !== 4'b0001) begin fails++; $display("FAIL tmo_rel: terr %0b done %b want 1 0001", timeout_err, req_done); end
      end
    end
    tick();
    tests++; if (timeout_err !== 1'b0 || req_done !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL tmo_after: terr %0b done %b busy %0b want 0 0000 0", timeout_err, req_done, busy); end
    xack = 1'b0;
    req_valid = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    drstn     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    xack      = 1'b0;
    ack_auto  = 1'b0;
    ack_lag   = 1;
    ack_hist  = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_drop_mid();
    test_reset_mid();
    test_stale_ack();
    test_random();
`ifdef CDC_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
